// File: rtl/fifo_avalon_arbiter.sv
// ============================================================================
// Module      : fifo_avalon_arbiter
// Description : Two-master round-robin arbiter in front of the FIFO wrapper's
//               Avalon-style slave port. It runs one register access at a time
//               and routes read data back to the master that issued the read.
//               Optional macro FIFO_ARB_FLOWCTRL_EN holds back DATA_ADDR pushes
//               while the FIFO is full and DATA_ADDR pops while it is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_avalon_arbiter #(
  parameter int         WIDTH     = 8,
  parameter logic [1:0] DATA_ADDR = 2'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       m0_address,
  input  logic             m0_write,
  input  logic             m0_read,
  input  logic [WIDTH-1:0] m0_writedata,
  output logic [WIDTH-1:0] m0_readdata,
  output logic             m0_readdatavalid,
  output logic             m0_waitrequest,
  input  logic [1:0]       m1_address,
  input  logic             m1_write,
  input  logic             m1_read,
  input  logic [WIDTH-1:0] m1_writedata,
  output logic [WIDTH-1:0] m1_readdata,
  output logic             m1_readdatavalid,
  output logic             m1_waitrequest,
  output logic [1:0]       avalon_address,
  output logic             avalon_write,
  output logic             avalon_read,
  output logic [WIDTH-1:0] avalon_writedata,
  input  logic [WIDTH-1:0] avalon_readdata,
  input  logic [1:0]       avalon_status,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic             op_read_q, op_read_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic             m0_elig, m1_elig;
  logic             pick_m1;
  logic             issue;

`ifdef FIFO_ARB_FLOWCTRL_EN
  // A write takes precedence over a simultaneous read, so it alone decides eligibility.
  assign m0_elig = m0_write ? !((m0_address == DATA_ADDR) && avalon_status[1])
                            : (m0_read && !((m0_address == DATA_ADDR) && avalon_status[0]));
  assign m1_elig = m1_write ? !((m1_address == DATA_ADDR) && avalon_status[1])
                            : (m1_read && !((m1_address == DATA_ADDR) && avalon_status[0]));
`else
  logic unused_flowctrl;
  assign unused_flowctrl = ^{avalon_status, DATA_ADDR};
  assign m0_elig = m0_write | m0_read;
  assign m1_elig = m1_write | m1_read;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_read_d   = op_read_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    pick_m1     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_elig || m1_elig) begin
          pick_m1   = (m0_elig && m1_elig) ? !last_q : m1_elig;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          last_d    = pick_m1;
          op_read_d = pick_m1 ? (m1_read && !m1_write) : (m0_read && !m0_write);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = op_read_q ? ST_RDWAIT : ST_IDLE;
      end
      ST_RDWAIT: begin
        if (grant_q[1]) begin
          m1_rdata_d  = avalon_readdata;
          m1_rvalid_d = 1'b1;
        end else begin
          m0_rdata_d  = avalon_readdata;
          m0_rvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      op_read_q   <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      op_read_q   <= op_read_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // The slave-side command is a pass-through of the owner's held command during ISSUE only.
  assign issue            = (state_q == ST_ISSUE);
  assign avalon_write     = issue && !op_read_q;
  assign avalon_read      = issue && op_read_q;
  assign avalon_address   = issue ? (grant_q[1] ? m1_address : m0_address) : 2'd0;
  assign avalon_writedata = issue ? (grant_q[1] ? m1_writedata : m0_writedata) : '0;
  assign m0_waitrequest   = !(issue && grant_q[0]);
  assign m1_waitrequest   = !(issue && grant_q[1]);
  assign grant            = (state_q == ST_IDLE) ? 2'b00 : grant_q;
  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rvalid_q;
  assign m1_readdatavalid = m1_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_avalon_arbiter.sv
// ============================================================================
// Module      : tb_fifo_avalon_arbiter
// Description : Self-checking bench for fifo_avalon_arbiter: directed scenarios
//               plus randomized masters against a transaction-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_avalon_arbiter;
  localparam int WIDTH = 8;
  localparam int RCYC  = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       m0_address, m1_address;
  logic             m0_write, m0_read, m1_write, m1_read;
  logic [WIDTH-1:0] m0_writedata, m1_writedata;
  logic [WIDTH-1:0] m0_readdata, m1_readdata;
  logic             m0_readdatavalid, m1_readdatavalid;
  logic             m0_waitrequest, m1_waitrequest;
  logic [1:0]       avalon_address;
  logic             avalon_write, avalon_read;
  logic [WIDTH-1:0] avalon_writedata, avalon_readdata;
  logic [1:0]       avalon_status;
  logic [1:0]       grant;

  int n_cmp = 0;
  int n_err = 0;

  fifo_avalon_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
    .avalon_address(avalon_address), .avalon_write(avalon_write),
    .avalon_read(avalon_read), .avalon_writedata(avalon_writedata),
    .avalon_readdata(avalon_readdata), .avalon_status(avalon_status),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = 2'd0; m0_write = 1'b0; m0_read = 1'b0; m0_writedata = '0;
    m1_address = 2'd0; m1_write = 1'b0; m1_read = 1'b0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  function automatic logic [33:0] obs_vec();
    return {m0_waitrequest, m1_waitrequest, avalon_write, avalon_read, avalon_address,
            avalon_writedata, grant, m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata};
  endfunction

  task automatic test_reset();
    logic [33:0] ov;
    reset = 1'b0;
    m0_write = 1'b1; m1_read = 1'b1; m0_writedata = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ov = obs_vec();
      n_cmp++;
      if (ov !== {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00}) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h required %h", i, ov, {2'b11, 32'h0});
      end
      cyc();
    end
    do_reset();
  endtask

  task automatic test_single_write();
    m0_address = 2'd0; m0_writedata = 8'hA5; m0_write = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m0_waitrequest, avalon_write, grant} !== 4'b1000) begin
      n_err++;
      $display("FAIL wr_req_cycle: wr/aw/grant=%b%b%b required 1000", m0_waitrequest, avalon_write, grant);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, avalon_write, avalon_read, avalon_address, avalon_writedata, grant}
        !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5, 2'b01}) begin
      n_err++;
      $display("FAIL wr_issue: w0=%b w1=%b aw=%b ar=%b a=%0d d=%h g=%b required 0 1 1 0 0 a5 01",
               m0_waitrequest, m1_waitrequest, avalon_write, avalon_read, avalon_address, avalon_writedata, grant);
    end
    cyc();
    m0_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m0_waitrequest, avalon_write, avalon_writedata, grant} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
      n_err++;
      $display("FAIL wr_after: w0=%b aw=%b d=%h g=%b required 1 0 00 00", m0_waitrequest, avalon_write, avalon_writedata, grant);
    end
    cyc();
  endtask

  task automatic test_single_read();
    avalon_readdata = 8'h3C; m1_address = 2'd0; m1_read = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({avalon_read, avalon_write, avalon_address, m1_waitrequest, m0_waitrequest, grant} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'b10}) begin
      n_err++;
      $display("FAIL rd_issue: ar=%b aw=%b a=%0d w1=%b w0=%b g=%b required 1 0 0 0 1 10",
               avalon_read, avalon_write, avalon_address, m1_waitrequest, m0_waitrequest, grant);
    end
    cyc();
    m1_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m1_readdatavalid, m0_readdatavalid, avalon_read, grant, m1_waitrequest} !== {1'b0, 1'b0, 1'b0, 2'b10, 1'b1}) begin
      n_err++;
      $display("FAIL rd_wait: rv1=%b rv0=%b ar=%b g=%b w1=%b required 0 0 0 10 1",
               m1_readdatavalid, m0_readdatavalid, avalon_read, grant, m1_waitrequest);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({m1_readdatavalid, m1_readdata, m0_readdatavalid, m0_readdata} !== {1'b1, 8'h3C, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL rd_valid: rv1=%b d1=%h rv0=%b d0=%h required 1 3c 0 00", m1_readdatavalid, m1_readdata, m0_readdatavalid, m0_readdata);
    end
    cyc();
    avalon_readdata = 8'h77;
    @(negedge clk);
    n_cmp++;
    if ({m1_readdatavalid, m1_readdata, m0_readdatavalid} !== {1'b0, 8'h3C, 1'b0}) begin
      n_err++;
      $display("FAIL rd_hold: rv1=%b d1=%h rv0=%b required 0 3c 0", m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
    cyc();
  endtask

  task automatic test_rw_same();
    m0_address = 2'd0; m0_writedata = 8'h11; m0_write = 1'b1; m0_read = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({avalon_write, avalon_read, avalon_writedata, m0_waitrequest} !== {1'b1, 1'b0, 8'h11, 1'b0}) begin
      n_err++;
      $display("FAIL rw_issue: aw=%b ar=%b d=%h w0=%b required 1 0 11 0", avalon_write, avalon_read, avalon_writedata, m0_waitrequest);
    end
    cyc();
    m0_write = 1'b0; m0_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({m0_readdatavalid, avalon_read, grant} !== 4'b0000) begin
        n_err++;
        $display("FAIL rw_after[%0d]: rv0=%b ar=%b g=%b required 0 0 00", i, m0_readdatavalid, avalon_read, grant);
      end
      cyc();
    end
  endtask

  task automatic test_contention();
    int wait0 = 0;
    int wait1 = 0;
    logic [1:0] eg;
    reset = 1'b0;
    idle_inputs();
    cyc();
    m0_address = 2'd1; m0_writedata = 8'h10; m0_write = 1'b1;
    m1_address = 2'd1; m1_writedata = 8'h20; m1_write = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      eg = (c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (grant !== eg || avalon_write !== (c % 2 == 1)) begin
        n_err++;
        $display("FAIL contention[%0d]: grant=%b aw=%b required %b %0d", c, grant, avalon_write, eg, c % 2);
      end
      if (!m0_waitrequest) begin
        n_cmp++;
        if (wait0 > 4) begin n_err++; $display("FAIL wait_m0: waited %0d required <=4", wait0); end
        wait0 = 0;
      end else wait0++;
      if (!m1_waitrequest) begin
        n_cmp++;
        if (wait1 > 4) begin n_err++; $display("FAIL wait_m1: waited %0d required <=4", wait1); end
        wait1 = 0;
      end else wait1++;
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_rdwait();
    avalon_readdata = 8'h5A; m0_address = 2'd0; m0_read = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({m0_waitrequest, avalon_read} !== 2'b01) begin
      n_err++;
      $display("FAIL rr_issue: w0=%b ar=%b required 0 1", m0_waitrequest, avalon_read);
    end
    cyc();
    m0_read = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m0_waitrequest, m0_readdatavalid, grant} !== 4'b1000) begin
      n_err++;
      $display("FAIL rr_in_reset: w0=%b rv0=%b g=%b required 1 0 00", m0_waitrequest, m0_readdatavalid, grant);
    end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m0_readdatavalid, m0_readdata, m0_waitrequest} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL rr_after: rv0=%b d0=%h w0=%b required 0 00 1", m0_readdatavalid, m0_readdata, m0_waitrequest);
    end
    cyc();
    m0_write = 1'b1; m0_writedata = 8'hC3; m1_write = 1'b1; m1_writedata = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if (m0_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL rr_no_valid: rv0=%b required 0", m0_readdatavalid);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({grant, avalon_writedata} !== {2'b01, 8'hC3}) begin
      n_err++;
      $display("FAIL rr_first_grant: g=%b d=%h required 01 c3", grant, avalon_writedata);
    end
    cyc();
    m0_write = 1'b0;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({grant, avalon_writedata} !== {2'b10, 8'h3C}) begin
      n_err++;
      $display("FAIL rr_second_grant: g=%b d=%h required 10 3c", grant, avalon_writedata);
    end
    cyc();
    m1_write = 1'b0;
    cyc();
  endtask

`ifdef FIFO_ARB_FLOWCTRL_EN
  task automatic test_flowctrl();
    avalon_status = 2'b10;
    m0_address = 2'd0; m0_writedata = 8'h99; m0_write = 1'b1;
    m1_address = 2'd0; m1_read = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({grant, m0_waitrequest, m1_waitrequest, avalon_read} !== {2'b10, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL fc_m1_first: g=%b w0=%b w1=%b ar=%b required 10 1 0 1", grant, m0_waitrequest, m1_waitrequest, avalon_read);
    end
    cyc();
    m1_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if ({grant, m0_waitrequest, avalon_write} !== {2'b00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL fc_blocked[%0d]: g=%b w0=%b aw=%b required 00 1 0", i, grant, m0_waitrequest, avalon_write);
      end
    end
    avalon_status = 2'b00;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({grant, m0_waitrequest, avalon_write, avalon_writedata} !== {2'b01, 1'b0, 1'b1, 8'h99}) begin
      n_err++;
      $display("FAIL fc_released: g=%b w0=%b aw=%b d=%h required 01 0 1 99", grant, m0_waitrequest, avalon_write, avalon_writedata);
    end
    cyc();
    idle_inputs();
    cyc();
  endtask
`endif

  // Reference: each arbitration decision fixes the cycle of acceptance,
  // the read-data slot and the next free cycle by simple arithmetic.
  task automatic test_random();
    logic [1:0] c_addr[2];
    logic       c_wr[2], c_rd[2];
    logic [7:0] c_dat[2];
    logic       pend[2];
    logic [7:0] rd_log[RCYC];
    logic [7:0] md[2];
    logic       ewr[2], erv[2], e[2];
    logic       aw, ar, last, op_rd;
    logic [1:0] aa, gr;
    logic [7:0] ad;
    logic [33:0] ev, ov;
    int free_at, issue_at, owner;
    do_reset();
    free_at = 0; issue_at = -10; owner = 0; op_rd = 1'b0; last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c_addr[i] = 2'd0; c_wr[i] = 1'b0; c_rd[i] = 1'b0; c_dat[i] = 8'h00; pend[i] = 1'b0; md[i] = 8'h00;
    end
    for (int k = 0; k < RCYC; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1'b1;
          c_addr[i] = 2'($urandom_range(0, 3));
          c_dat[i]  = 8'($urandom);
          c_wr[i]   = 1'($urandom_range(0, 1));
          c_rd[i]   = c_wr[i] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      m0_address = c_addr[0]; m0_writedata = c_dat[0]; m0_write = pend[0] & c_wr[0]; m0_read = pend[0] & c_rd[0];
      m1_address = c_addr[1]; m1_writedata = c_dat[1]; m1_write = pend[1] & c_wr[1]; m1_read = pend[1] & c_rd[1];
      avalon_readdata = 8'($urandom);
      rd_log[k] = avalon_readdata;
      avalon_status = 2'($urandom_range(0, 3));

      ewr[0] = 1'b1; ewr[1] = 1'b1; erv[0] = 1'b0; erv[1] = 1'b0;
      aw = 1'b0; ar = 1'b0; aa = 2'd0; ad = 8'h00; gr = 2'b00;
      if (k == issue_at) begin
        ewr[owner] = 1'b0;
        aw = !op_rd; ar = op_rd;
        aa = c_addr[owner]; ad = c_dat[owner];
      end
      if (k == issue_at || (op_rd && k == issue_at + 1)) gr = (owner == 1) ? 2'b10 : 2'b01;
      if (op_rd && k == issue_at + 2) begin
        erv[owner] = 1'b1;
        md[owner]  = rd_log[issue_at + 1];
      end
      if (k >= free_at) begin
        for (int i = 0; i < 2; i++) begin
`ifdef FIFO_ARB_FLOWCTRL_EN
          e[i] = pend[i] && (c_wr[i] ? !(c_addr[i] == 2'd0 && avalon_status[1])
                                     : !(c_addr[i] == 2'd0 && avalon_status[0]));
`else
          e[i] = pend[i];
`endif
        end
        if (e[0] || e[1]) begin
          owner    = (e[0] && e[1]) ? (last ? 0 : 1) : (e[1] ? 1 : 0);
          op_rd    = c_rd[owner] && !c_wr[owner];
          issue_at = k + 1;
          free_at  = k + (op_rd ? 3 : 2);
          last     = (owner == 1);
        end
      end
      ev = {ewr[0], ewr[1], aw, ar, aa, ad, gr, erv[0], erv[1], md[0], md[1]};

      @(negedge clk);
      ov = obs_vec();
      n_cmp++;
      if (ov !== ev) begin
        n_err++;
        $display("FAIL rand[%0d]: got %h required %h", k, ov, ev);
      end
      if (!m0_waitrequest) pend[0] = 1'b0;
      if (!m1_waitrequest) pend[1] = 1'b0;
      cyc();
    end
    idle_inputs();
    avalon_status = 2'b00;
    for (int i = 0; i < 4; i++) cyc();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    avalon_readdata = '0;
    avalon_status   = 2'b00;
    test_reset();
    test_single_write();
    test_single_read();
    test_rw_same();
    test_contention();
    test_reset_rdwait();
`ifdef FIFO_ARB_FLOWCTRL_EN
    test_flowctrl();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
